// File: rtl/spare_signal_generator_if.sv
// Candidate handshake bundle between the spare signal generator and its consumer.
// The generator owns valid and payload; the consumer owns ready.
interface spare_signal_generator_if #(
  parameter int unsigned DSSS_W = 8,
  parameter int unsigned RLSS_W = 4,
  parameter int unsigned IDX_W  = 16
);
  logic              cand_valid;
  logic              cand_ready;
  logic [DSSS_W-1:0] dsss;
  logic [RLSS_W-1:0] rlss;
  logic [IDX_W-1:0]  cand_idx;

  modport master (
    output cand_valid,
    output dsss,
    output rlss,
    output cand_idx,
    input  cand_ready
  );

  modport slave (
    input  cand_valid,
    input  dsss,
    input  rlss,
    input  cand_idx,
    output cand_ready
  );
endinterface

// File: rtl/spare_signal_generator.sv
// Spare signal generator: walks every DSSS word with DSSS_ONES set bits (outer loop) and every
// RLSS word with RLSS_ONES set bits (inner loop) in increasing order, one candidate per accepted
// beat. Optional feature macro: STOP_ON_HIT_EN -- when defined, a checker hit ends the run and
// latches the hit candidate into found_dsss/found_rlss; when undefined, hit is ignored and the
// found outputs are tied low.
module spare_signal_generator #(
  parameter int unsigned DSSS_W    = 8,
  parameter int unsigned DSSS_ONES = 4,
  parameter int unsigned RLSS_W    = 4,
  parameter int unsigned RLSS_ONES = 2,
  parameter int unsigned IDX_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    hit,
  spare_signal_generator_if.master cand,
  output logic                    busy,
  output logic                    done,
  output logic                    found,
  output logic [DSSS_W-1:0]       found_dsss,
  output logic [RLSS_W-1:0]       found_rlss
);

  // Lowest legal word has the ones packed at the bottom, highest has them packed at the top.
  localparam logic [DSSS_W-1:0] DSSS_FIRST = DSSS_W'((64'd1 << DSSS_ONES) - 64'd1);
  localparam logic [DSSS_W-1:0] DSSS_LAST  = DSSS_FIRST << (DSSS_W - DSSS_ONES);
  localparam logic [RLSS_W-1:0] RLSS_FIRST = RLSS_W'((64'd1 << RLSS_ONES) - 64'd1);
  localparam logic [RLSS_W-1:0] RLSS_LAST  = RLSS_FIRST << (RLSS_W - RLSS_ONES);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Next larger word with the same popcount (Gosper's hack). The divide by the lowest set bit
  // is replaced by a right shift of its index.
  function automatic logic [31:0] next_combo(input logic [31:0] x);
    logic [31:0] low;
    logic [31:0] ripple;
    logic [31:0] ones;
    int          tz;
    low    = x & (~x + 32'd1);
    ripple = x + low;
    tz     = 0;
    for (int i = 31; i >= 0; i--) begin
      if (x[i]) tz = i;
    end
    ones = ((ripple ^ x) >> 2) >> tz;
    return ripple | ones;
  endfunction

  state_e            state_q;
  logic              valid_q;
  logic [DSSS_W-1:0] dsss_q;
  logic [RLSS_W-1:0] rlss_q;
  logic [IDX_W-1:0]  idx_q;
  logic              done_q;

  logic [DSSS_W-1:0] dsss_next;
  logic [RLSS_W-1:0] rlss_next;
  logic              last_pair;

`ifdef STOP_ON_HIT_EN
  logic              found_q;
  logic [DSSS_W-1:0] found_dsss_q;
  logic [RLSS_W-1:0] found_rlss_q;
  logic [DSSS_W-1:0] last_dsss_q;
  logic [RLSS_W-1:0] last_rlss_q;
`endif

  // Successor words and end-of-enumeration detect for the current candidate.
  always_comb begin
    dsss_next = DSSS_W'(next_combo(32'(dsss_q)));
    rlss_next = RLSS_W'(next_combo(32'(rlss_q)));
    last_pair = (dsss_q == DSSS_LAST) && (rlss_q == RLSS_LAST);
  end

  // Enumeration FSM with registered candidate, valid and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      valid_q      <= 1'b0;
      dsss_q       <= '0;
      rlss_q       <= '0;
      idx_q        <= '0;
      done_q       <= 1'b0;
`ifdef STOP_ON_HIT_EN
      found_q      <= 1'b0;
      found_dsss_q <= '0;
      found_rlss_q <= '0;
      last_dsss_q  <= '0;
      last_rlss_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // abort wins over a coincident start
          if (start && !abort) begin
            state_q <= StRun;
            valid_q <= 1'b1;
            dsss_q  <= DSSS_FIRST;
            rlss_q  <= RLSS_FIRST;
            idx_q   <= '0;
`ifdef STOP_ON_HIT_EN
            found_q      <= 1'b0;
            found_dsss_q <= '0;
            found_rlss_q <= '0;
`endif
          end
        end
        StRun: begin
          if (abort) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
          end
`ifdef STOP_ON_HIT_EN
          // The verdict refers to the previously accepted beat; any beat accepted now is dropped.
          else if (hit) begin
            state_q      <= StDone;
            valid_q      <= 1'b0;
            done_q       <= 1'b1;
            found_q      <= 1'b1;
            found_dsss_q <= last_dsss_q;
            found_rlss_q <= last_rlss_q;
          end
`endif
          else if (cand.cand_ready) begin
`ifdef STOP_ON_HIT_EN
            last_dsss_q <= dsss_q;
            last_rlss_q <= rlss_q;
`endif
            if (last_pair) begin
              state_q <= StDone;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              // RLSS is the inner loop; DSSS steps only when RLSS wraps.
              if (rlss_q == RLSS_LAST) begin
                rlss_q <= RLSS_FIRST;
                dsss_q <= dsss_next;
              end else begin
                rlss_q <= rlss_next;
              end
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cand.cand_valid = valid_q;
  assign cand.dsss       = dsss_q;
  assign cand.rlss       = rlss_q;
  assign cand.cand_idx   = idx_q;
  assign busy            = (state_q != StIdle);
  assign done            = done_q;

`ifdef STOP_ON_HIT_EN
  assign found      = found_q;
  assign found_dsss = found_dsss_q;
  assign found_rlss = found_rlss_q;
`else
  logic unused_hit;
  assign unused_hit = hit;
  assign found      = 1'b0;
  assign found_dsss = '0;
  assign found_rlss = '0;
`endif

endmodule

// File: tb/tb_spare_signal_generator.sv
// Bench for spare_signal_generator: a list-based reference model of the enumeration order
// checked against the DUT every negative clock edge, plus directed scenario checks.
module tb_spare_signal_generator;

  localparam int NUM = 420;

`ifdef STOP_ON_HIT_EN
  localparam int EXP_HIT_BEATS = 38;
  localparam int EXP_HIT_FOUND = 1;
`else
  localparam int EXP_HIT_BEATS = NUM;
  localparam int EXP_HIT_FOUND = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       hit = 1'b0;
  logic       busy;
  logic       done;
  logic       found;
  logic [7:0] found_dsss;
  logic [3:0] found_rlss;

  spare_signal_generator_if bus ();

  spare_signal_generator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .hit        (hit),
    .cand       (bus),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .found_dsss (found_dsss),
    .found_rlss (found_rlss)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference ordering: all legal pairs, DSSS ascending outer, RLSS ascending inner.
  logic [7:0] exp_d [NUM];
  logic [3:0] exp_r [NUM];

  typedef enum {MIdle, MRun, MDone} mphase_e;
  mphase_e    m_phase = MIdle;
  int         m_idx = 0;
  int         beats = 0;
  logic       m_found = 1'b0;
  logic [7:0] m_fd = '0;
  logic [3:0] m_fr = '0;
  logic [7:0] m_last_d = '0;
  logic [3:0] m_last_r = '0;
  bit         seen [4096];

  // Compare DUT against the model, then advance the model by what the next edge will sample.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase  = MIdle;
      m_found  = 1'b0;
      m_fd     = '0;
      m_fr     = '0;
      m_last_d = '0;
      m_last_r = '0;
      chk("rst_valid", bus.cand_valid, 0);
      chk("rst_dsss", bus.dsss, 0);
      chk("rst_rlss", bus.rlss, 0);
      chk("rst_idx", bus.cand_idx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_found", found, 0);
      chk("rst_found_pair", {found_dsss, found_rlss}, 0);
    end else begin
      chk("valid", bus.cand_valid, m_phase == MRun);
      chk("busy", busy, m_phase != MIdle);
      chk("done", done, m_phase == MDone);
      chk("found", found, m_found);
      chk("found_pair", {found_dsss, found_rlss}, {m_fd, m_fr});
      if (m_phase == MRun) begin
        chk("idx", bus.cand_idx, m_idx);
        chk("dsss", bus.dsss, exp_d[m_idx]);
        chk("rlss", bus.rlss, exp_r[m_idx]);
        chk("dsss_popcount", $countones(bus.dsss), 4);
        chk("rlss_popcount", $countones(bus.rlss), 2);
        if (m_idx == 0)   chk("pin_idx0", {bus.dsss, bus.rlss}, 12'h0F3);
        if (m_idx == 1)   chk("pin_idx1", {bus.dsss, bus.rlss}, 12'h0F5);
        if (m_idx == 6)   chk("pin_idx6", {bus.dsss, bus.rlss}, 12'h173);
        if (m_idx == 419) chk("pin_idx419", {bus.dsss, bus.rlss}, 12'hF0C);
      end
      case (m_phase)
        MIdle: begin
          if (start && !abort) begin
            m_phase = MRun;
            m_idx   = 0;
            beats   = 0;
            m_found = 1'b0;
            m_fd    = '0;
            m_fr    = '0;
            seen    = '{default: 1'b0};
          end
        end
        MRun: begin
          if (abort) begin
            m_phase = MIdle;
          end
`ifdef STOP_ON_HIT_EN
          else if (hit) begin
            m_found = 1'b1;
            m_fd    = m_last_d;
            m_fr    = m_last_r;
            m_phase = MDone;
          end
`endif
          else if (bus.cand_ready) begin
            beats++;
            chk("unique", 32'(seen[{bus.dsss, bus.rlss}]), 0);
            seen[{bus.dsss, bus.rlss}] = 1'b1;
            m_last_d = exp_d[m_idx];
            m_last_r = exp_r[m_idx];
            if (m_idx == NUM - 1) m_phase = MDone;
            else m_idx++;
          end
        end
        default: m_phase = MIdle;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idx(input int target);
    for (int n = 0; n < 3000; n++) begin
      if (bus.cand_valid && bus.cand_idx == 16'(target)) return;
      step();
    end
    checks++;
    errors++;
    $display("FAIL wait_idx: idx %0d never presented", target);
  endtask

  task automatic wait_done();
    for (int n = 0; n < 3000; n++) begin
      if (done) return;
      step();
    end
    checks++;
    errors++;
    $display("FAIL wait_done: no done pulse within bound");
  endtask

  initial begin
    int k;
    k = 0;
    for (int d = 0; d < 256; d++) begin
      if ($countones(d) == 4) begin
        for (int r = 0; r < 16; r++) begin
          if ($countones(r) == 2) begin
            exp_d[k] = 8'(d);
            exp_r[k] = 4'(r);
            k++;
          end
        end
      end
    end
    chk("model_count", k, NUM);
    chk("model_idx37", {exp_d[37], exp_r[37]}, 12'h2B5);
    chk("model_idx419", {exp_d[419], exp_r[419]}, 12'hF0C);

    bus.cand_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Full run with backpressure at idx10 and an ignored start at idx50.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("first_beat", {bus.cand_valid, bus.cand_idx, bus.dsss, bus.rlss}, {1'b1, 16'd0, 12'h0F3});
    wait_idx(10);
    bus.cand_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", {bus.cand_valid, bus.cand_idx, bus.dsss, bus.rlss},
          {1'b1, 16'd10, exp_d[10], exp_r[10]});
    end
    bus.cand_ready = 1'b1;
    step();
    chk("bp_release_idx", bus.cand_idx, 11);
    wait_idx(50);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_in_run_idx", bus.cand_idx, 51);
    wait_done();
    chk("run_a_beats", beats, NUM);
    step();
    chk("after_done_busy", busy, 0);
    chk("after_done_done", done, 0);

    // start and abort together in idle: stays idle.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_valid", bus.cand_valid, 0);

    // Abort at idx100, then restart.
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idx(100);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", bus.cand_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    step();
    chk("abort_no_done", done, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_beat", {bus.cand_valid, bus.cand_idx, bus.dsss, bus.rlss}, {1'b1, 16'd0, 12'h0F3});

    // Asynchronous reset at idx200, then a full run.
    wait_idx(200);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cand", {bus.cand_valid, bus.cand_idx, bus.dsss, bus.rlss}, 0);
    chk("async_rst_status", {busy, done, found}, 0);
    step();
    rst_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done();
    chk("run_c_beats", beats, NUM);
    step();

    // hit one cycle after the idx37 handshake.
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idx(37);
    step();
    hit = 1'b1;
    step();
    hit = 1'b0;
    wait_done();
    chk("hit_beats", beats, EXP_HIT_BEATS);
    chk("hit_found", found, EXP_HIT_FOUND);
`ifdef STOP_ON_HIT_EN
    chk("hit_found_pair", {found_dsss, found_rlss}, 12'h2B5);
`endif
    repeat (3) step();
    chk("end_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
